nes_pad_device: RTL and testbench
=================================

Name: nes_pad_device

Overview:
Device-side (controller-end) model of the NES pad serial protocol, driven by a console or host.
- Parallel-loads an 8-bit button vector while latch is high.
- On each rising edge of the host clock, shifts the next button out on the active-low data line.
- Samples latch and clock through synchronisers and glitch filters.
- Used to present internally generated or remapped button state to an external NES-protocol host, and as a loopback target for the team's controller reader.

Parameters:
FILTER_LEN, 2, consecutive clk cycles a synchronised input must hold a new level before it is accepted (≥1)
NES_BITS, 8, bits per frame (fixed; do not override)

Ports:
clk  input  1  system clock; sole clock domain
rst_n  input  1  asynchronous active-low reset
buttons  input  8  pressed=1, synchronous to clk; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
nes_latch  input  1  latch from host, asynchronous, active-high
nes_clock  input  1  shift clock from host, asynchronous, shift on rising edge
nes_data  output  1  serial data to host, active-low (0 = pressed)
frame_done  output  1  one-clk pulse when the 8th bit has been shifted out
busy  output  1  high from latch fall until frame_done or next latch
latch_cnt  output  8  count of accepted latch rising edges, wraps 255->0

Behaviour:
- Reset (async assert, sync release):
  - Shift register, sync flops, filter counters, filtered levels and edge-history flops = 0.
  - bit_cnt=0, state=IDLE.
  - nes_data=1, frame_done=0, busy=0, latch_cnt=0.
- Input path (per input, 2 sync flops then filter):
  - Let s = second sync flop.
  - If s==filt: cnt<=0.
  - If s!=filt and cnt==FILTER_LEN-1: filt<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Pulses shorter than FILTER_LEN clks after sync are dropped.
- Edge detect: rise = filt & ~filt_q, fall = ~filt & filt_q (filt_q registered).
- Latency: nes_data changes on clk edge 3+FILTER_LEN, counted from the first edge that samples the new pin level (FILTER_LEN=2 -> edge 5).
- shreg[7:0] is active-high; nes_data = ~shreg[0], driven straight from a flop, glitch-free.
- States:
  - IDLE: nes_data reflects shreg. Latch filt high -> LOAD.
  - LOAD: every cycle shreg<=buttons (transparent parallel load, so nes_data tracks ~buttons[0]); bit_cnt<=0. Latch rise increments latch_cnt. Clock edges ignored. Latch fall -> SHIFT with the last loaded value held, busy<=1.
  - SHIFT: on clock rise, shreg<={1'b0,shreg[7:1]} and bit_cnt++. The rise taking bit_cnt 7->8 asserts frame_done for 1 cycle, clears busy -> DONE.
  - DONE: further clock rises keep shifting zeros, so nes_data stays 1. bit_cnt saturates at 8.
  - Latch high in any state -> LOAD.
- Boundary and simultaneous cases:
  - Latch high and clock rise in the same cycle: latch wins (load, no shift).
  - Latch rise mid-frame aborts the frame: busy<=0, no frame_done.
  - buttons change during SHIFT/DONE has no effect until the next latch.
  - latch_cnt wraps 255->0 silently.
  - rst_n mid-frame: immediate return to reset values, nes_data=1.
- No combinational path from any input to any output.

Decomposition:
- Package nes_pkg:
  - NES_BITS=8.
  - Button index constants BTN_A..BTN_RIGHT (0..7).
  - State enum IDLE/LOAD/SHIFT/DONE as 2-bit localparams.
  - Shared by this block and the controller reader.
- Sub-module nes_sync_filter (2-flop sync + FILTER_LEN filter + rise/fall outputs, parameter FILTER_LEN), instantiated for nes_latch and nes_clock.
- Top: FSM, shreg, bit_cnt, latch_cnt.

Test Plan:
1. Reset then idle, buttons=8'hFF, no latch -> nes_data=1, busy=0, latch_cnt=0.
2. buttons=8'b1010_0101, latch pulse 10 clks, then 8 clock pulses (10 clks high / 10 low) -> nes_data before each rise = 0,1,0,1,1,0,1,0; frame_done pulses once, 3+FILTER_LEN clks after the 8th rise; latch_cnt=1; nes_data=1 afterwards.
3. Same frame with 4 extra clock pulses -> nes_data stays 1, no second frame_done, bit_cnt holds 8.
4. 1-clk glitches on nes_clock and nes_latch with FILTER_LEN=2 -> no shift, no load, latch_cnt unchanged.
5. Latch asserted after the 3rd shift, buttons=8'h01 -> busy drops, no frame_done, nes_data=0 (A) 5 clks after the latch pin edge, new frame streams correctly.
6. rst_n low after the 4th shift, then release -> nes_data=1 immediately on assertion, all counters 0, next latch/frame behaves as in test 2; 256 latches -> latch_cnt wraps to 0.

Source files
------------

// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES pad protocol constants, button indices and FSM states
package nes_pkg;

  localparam int NES_BITS  = 8;
  localparam int BIT_CNT_W = $clog2(NES_BITS + 1);

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [1:0] nes_state_t;

  localparam nes_state_t IDLE  = 2'd0;
  localparam nes_state_t LOAD  = 2'd1;
  localparam nes_state_t SHIFT = 2'd2;
  localparam nes_state_t DONE  = 2'd3;

endpackage

// File: rtl/nes_pad_device_if.sv
// rtl/nes_pad_device_if.sv - NES pad serial wires between host (master) and pad (slave)
interface nes_pad_device_if;

  logic nes_latch;
  logic nes_clock;
  logic nes_data;

  modport master (output nes_latch, output nes_clock, input nes_data);
  modport slave  (input nes_latch, input nes_clock, output nes_data);

endinterface

// File: rtl/nes_sync_filter.sv
// rtl/nes_sync_filter.sv - two-flop synchroniser, level glitch filter and edge detect
module nes_sync_filter #(
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          filt;
  logic          filt_q;

  // A new level must persist FILTER_LEN cycles after sync before it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b00;
      cnt    <= '0;
      filt   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      sync   <= {sync[0], pin};
      filt_q <= filt;
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = filt;
  assign rise  = filt & ~filt_q;
  assign fall  = ~filt & filt_q;

endmodule

// File: rtl/nes_pad_device.sv
// rtl/nes_pad_device.sv - controller-end NES pad: parallel load on latch, shift on host clock
module nes_pad_device
  import nes_pkg::*;
#(
  parameter int FILTER_LEN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NES_BITS-1:0] buttons,
  nes_pad_device_if.slave     pad,
  output logic                frame_done,
  output logic                busy,
  output logic [7:0]          latch_cnt
);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl_unused, clk_rise, clk_fall_unused;

  nes_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_latch_filt (
    .clk(clk), .rst_n(rst_n), .pin(pad.nes_latch),
    .level(latch_lvl), .rise(latch_rise), .fall(latch_fall)
  );

  nes_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clock_filt (
    .clk(clk), .rst_n(rst_n), .pin(pad.nes_clock),
    .level(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall_unused)
  );

  nes_state_t           state, state_next;
  logic [NES_BITS-1:0]  shreg, shreg_next;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic                 busy_next, done_next, data_q;
  logic [7:0]           latch_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Latch high overrides everything, including a same-cycle clock rise
  always_comb begin
    state_next = state;
    if (latch_lvl) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD:    if (latch_fall) state_next = SHIFT;
        SHIFT:   if (clk_rise && bit_cnt == BIT_CNT_W'(NES_BITS - 1)) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    shreg_next     = shreg;
    bit_cnt_next   = bit_cnt;
    busy_next      = busy;
    done_next      = 1'b0;
    latch_cnt_next = latch_cnt;
    if (latch_lvl) begin
      shreg_next   = buttons;
      bit_cnt_next = '0;
      busy_next    = 1'b0;
      if (latch_rise) latch_cnt_next = latch_cnt + 8'd1;
    end else begin
      case (state)
        LOAD: if (latch_fall) busy_next = 1'b1;
        SHIFT: if (clk_rise) begin
          shreg_next   = {1'b0, shreg[NES_BITS-1:1]};
          bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_CNT_W'(NES_BITS - 1)) begin
            done_next = 1'b1;
            busy_next = 1'b0;
          end
        end
        DONE: if (clk_rise) shreg_next = {1'b0, shreg[NES_BITS-1:1]};
        default: shreg_next = shreg;
      endcase
    end
  end

  // nes_data gets its own flop so the pin never sees combinational logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      latch_cnt  <= 8'd0;
      data_q     <= 1'b1;
    end else begin
      shreg      <= shreg_next;
      bit_cnt    <= bit_cnt_next;
      busy       <= busy_next;
      frame_done <= done_next;
      latch_cnt  <= latch_cnt_next;
      data_q     <= ~shreg_next[0];
    end
  end

  assign pad.nes_data = data_q;

endmodule

// File: tb/tb_nes_pad_device.sv
// tb/tb_nes_pad_device.sv - scoreboard bench for nes_pad_device against a frame-level model
module tb_nes_pad_device;

  localparam int FL  = 2;
  localparam int LAT = 3 + FL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] buttons;
  logic       frame_done, busy;
  logic [7:0] latch_cnt;

  nes_pad_device_if pad();

  nes_pad_device #(.FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .pad(pad.slave),
    .frame_done(frame_done), .busy(busy), .latch_cnt(latch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    kind;
    int    value;
  } chk_t;

  chk_t chk_q[$];
  int   frame_q[$];
  int   errors = 0;
  int   checks = 0;

  // Frame-level model: the pressed set captured at the latest latch and how many bits left
  logic [7:0] m_btn = 8'h00;
  int         m_shifts = 8;
  int         m_cnt = 0;

  function automatic int m_data();
    return (m_shifts < 8 && m_btn[m_shifts]) ? 0 : 1;
  endfunction

  task automatic push_chk(input string n, input int kind, input int v);
    chk_t c;
    c.name = n; c.kind = kind; c.value = v;
    chk_q.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    chk_t c;
    int   act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        0:       act = int'(pad.nes_data);
        1:       act = int'(busy);
        default: act = int'(latch_cnt);
      endcase
      checks++;
      if (act != c.value) begin
        errors++;
        $display("FAIL %s at cycle %0d: got %0d expected %0d", c.name, cyc, act, c.value);
      end
    end
    if (frame_done) begin
      checks++;
      if (frame_q.size() == 0) begin
        errors++;
        $display("FAIL frame_done_unexpected at cycle %0d: got 1 expected 0", cyc);
      end else begin
        act = frame_q.pop_front();
        if (act != cyc) begin
          errors++;
          $display("FAIL frame_done_cycle: got %0d expected %0d", cyc, act);
        end
      end
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #2;
    end
  endtask

  task automatic do_latch(input int h, input int l);
    pad.nes_latch = 1'b1;
    tick(LAT - 1);
    push_chk("data_before_load", 0, m_data());
    tick(1);
    m_btn    = buttons;
    m_shifts = 0;
    m_cnt    = (m_cnt + 1) % 256;
    push_chk("data_after_load", 0, m_data());
    push_chk("busy_in_latch", 1, 0);
    tick(h - LAT);
    pad.nes_latch = 1'b0;
    tick(l);
    push_chk("latch_cnt", 2, m_cnt);
  endtask

  task automatic do_clock(input int l, input int h);
    tick(l);
    push_chk("data_before_rise", 0, m_data());
    push_chk("busy_before_rise", 1, (m_shifts < 8) ? 1 : 0);
    pad.nes_clock = 1'b1;
    if (m_shifts == 7) frame_q.push_back(cyc + LAT);
    if (m_shifts < 8) m_shifts++;
    buttons = 8'($urandom);
    tick(h);
    pad.nes_clock = 1'b0;
  endtask

  task automatic do_glitch(input bit on_clock);
    if (on_clock) pad.nes_clock = 1'b1;
    else          pad.nes_latch = 1'b1;
    tick(1);
    pad.nes_clock = 1'b0;
    pad.nes_latch = 1'b0;
    tick(6);
    push_chk("data_after_glitch", 0, m_data());
    push_chk("latch_cnt_after_glitch", 2, m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_shifts = 8;
    m_cnt    = 0;
    push_chk("reset_data", 0, 1);
    push_chk("reset_busy", 1, 0);
    push_chk("reset_latch_cnt", 2, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    pad.nes_latch = 1'b0;
    pad.nes_clock = 1'b0;
    buttons = 8'hFF;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(8);

    push_chk("idle_data", 0, 1);
    push_chk("idle_busy", 1, 0);
    push_chk("idle_latch_cnt", 2, 0);
    repeat (2) do_clock(5, 5);

    buttons = 8'b1010_0101;
    do_latch(10, 10);
    repeat (8) do_clock(10, 10);
    repeat (4) do_clock(10, 10);
    tick(10);
    push_chk("data_after_frame", 0, 1);
    push_chk("busy_after_frame", 1, 0);

    buttons = 8'($urandom);
    do_latch(LAT + 3, 6);
    repeat (2) do_clock(6, 6);
    do_glitch(1'b1);
    do_glitch(1'b0);
    repeat (6) do_clock(6, 6);

    buttons = 8'($urandom);
    do_latch(LAT + 2, 6);
    repeat (3) do_clock(6, 6);
    buttons = 8'h01;
    do_latch(LAT + 2, 6);
    repeat (8) do_clock(6, 6);

    buttons = 8'($urandom);
    do_latch(LAT + 2, 6);
    repeat (2) do_clock(6, 6);
    buttons = 8'($urandom);
    tick(4);
    pad.nes_clock = 1'b1;
    do_latch(LAT + 2, 6);
    pad.nes_clock = 1'b0;
    repeat (8) do_clock(6, 6);

    buttons = 8'($urandom);
    do_latch(LAT + 2, 6);
    repeat (4) do_clock(6, 6);
    tick(3);
    do_reset();
    buttons = 8'b1010_0101;
    do_latch(10, 10);
    repeat (8) do_clock(10, 10);

    for (int i = 0; i < 8; i++) begin
      int n;
      buttons = 8'($urandom);
      do_latch($urandom_range(LAT + 1, LAT + 6), $urandom_range(4, 9));
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 12);
      for (int j = 0; j < n; j++) do_clock($urandom_range(4, 10), $urandom_range(4, 10));
    end

    tick(10);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      buttons = 8'($urandom);
      do_latch(LAT + 1, 5);
    end

    tick(20);
    checks++;
    if (frame_q.size() != 0) begin
      errors++;
      $display("FAIL frame_done_missing: got %0d pending expected 0", frame_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
